// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M divide unit: funct3 codes, FSM states and
// operation-decoding helpers.
package rv32m_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  // Unlisted funct3 codes behave as DIVU: unsigned and quotient-selecting.
  function automatic logic f3_is_signed(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic f3_is_rem(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  function automatic logic f3_is_divu(input logic [2:0] f3);
    return !f3_is_signed(f3) && !f3_is_rem(f3);
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the
// divisor magnitude, and keep the difference when it is non-negative.
module div_iter_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] div_in,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    trial   = shifted - {1'b0, div_in};
    if (trial[XLEN]) begin
      rem_out = shifted[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end else begin
      rem_out = trial[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/rv32m_div_unit.sv
// EX-stage multi-cycle divider for DIV/DIVU/REM/REMU: one restoring step per
// cycle on operand magnitudes, with a one-cycle fast path for /0 and overflow.
module rv32m_div_unit
  import rv32m_pkg::*;
#(
  parameter int unsigned XLEN  = DEFAULT_XLEN,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            is_rem_q, is_rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_q, rd_d;

  logic [XLEN-1:0] step_rem, step_quo;
  logic            sgn;

  div_iter_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .div_in  (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    is_rem_d = is_rem_q;
    result_d = result_q;
    rd_d     = rd_q;
    sgn      = f3_is_signed(funct3);

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          rd_d     = rd_in;
          is_rem_d = f3_is_rem(funct3);
          if (rs2_data == '0) begin
            state_d  = S_DONE;
            result_d = f3_is_rem(funct3) ? rs1_data : '1;
          end else if (sgn && rs1_data == MIN_NEG && rs2_data == '1) begin
            state_d  = S_DONE;
            result_d = f3_is_rem(funct3) ? '0 : MIN_NEG;
          end else begin
            state_d = S_CALC;
            cnt_d   = CNT_W'(XLEN - 1);
            rem_d   = '0;
            quo_d   = (sgn && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
            dvs_d   = (sgn && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
            qneg_d  = sgn && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
            rneg_d  = sgn && rs1_data[XLEN-1];
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - 1'b1;
          // Sign correction folded into the final step so DONE only presents result_q.
          if (cnt_q == '0) begin
            state_d  = S_DONE;
            cnt_d    = '0;
            result_d = is_rem_q ? (rneg_q ? -step_rem : step_rem)
                                : (qneg_q ? -step_quo : step_quo);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      is_rem_q <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      is_rem_q <= is_rem_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  // A flush landing in the DONE cycle kills the op, so it suppresses valid too.
  assign busy   = (state_q == S_CALC);
  assign valid  = (state_q == S_DONE) && !flush;
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_rv32m_div_unit.sv
// Bench for rv32m_div_unit: an operation-level latency/arithmetic model checked
// every cycle, plus directed vectors with literal expected results.
module tb_rv32m_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_in = '0;
  logic        flush = 1'b0;
  logic        busy, valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int errors = 0;
  int checks = 0;

  rv32m_div_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in), .flush(flush),
    .busy(busy), .valid(valid), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Architectural RV32M results, straight from the ISA rules.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    bit sg = (f3 == 3'b100) || (f3 == 3'b110);
    bit rm = (f3 == 3'b110) || (f3 == 3'b111);
    int sa = a;
    int sb = b;
    if (b == 0) return rm ? a : 32'hFFFF_FFFF;
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'h0 : 32'h8000_0000;
    if (sg) return rm ? 32'(sa % sb) : 32'(sa / sb);
    return rm ? a % b : a / b;
  endfunction

  function automatic bit ref_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit sg = (f3 == 3'b100) || (f3 == 3'b110);
    return (b == 0) || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Operation-level model: age counts edges since acceptance; DONE is at age 0
  // (fast path) or 32 (iterated), and the unit is free again one edge later.
  bit          m_act = 0;
  int          m_age = 0;
  int          m_done = 0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_rd = '0;
  logic [31:0] h_res = '0;
  logic [4:0]  h_rd = '0;
  bit          h_known = 0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_act   <= 0;
      m_age   <= 0;
      h_res   <= '0;
      h_rd    <= '0;
      h_known <= 1;
      chk_en  <= 1;
    end else if (m_act) begin
      if (flush) begin
        m_act   <= 0;
        h_known <= 0;
      end else begin
        m_age <= m_age + 1;
        if (m_age + 1 > m_done) begin
          m_act   <= 0;
          h_res   <= m_res;
          h_rd    <= m_rd;
          h_known <= 1;
        end
      end
    end else if (start && !flush) begin
      m_act  <= 1;
      m_age  <= 0;
      m_done <= ref_fast(funct3, rs1_data, rs2_data) ? 0 : 32;
      m_res  <= ref_result(funct3, rs1_data, rs2_data);
      m_rd   <= rd_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_busy, exp_valid;
      exp_busy  = m_act && (m_done == 32) && (m_age < 32);
      exp_valid = m_act && (m_age == m_done) && !flush;
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("valid", 32'(valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("result", result, m_res);
        chk("rd_out", 32'(rd_out), 32'(m_rd));
      end else if (!m_act && h_known) begin
        chk("result_hold", result, h_res);
        chk("rd_hold", 32'(rd_out), 32'(h_rd));
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(posedge clk); #1;
    start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0; rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
  endtask

  task automatic wait_valid(input logic [31:0] lit, input logic [4:0] rd);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk("valid_timeout", 32'(seen), 32'd1);
    chk("lit_result", result, lit);
    chk("lit_rd", 32'(rd_out), 32'(rd));
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15] = '{
    '{3'b100, 32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFD},
    '{3'b110, 32'hFFFF_FFF9, 32'd2,         5'd1,  32'hFFFF_FFFF},
    '{3'b101, 32'hFFFF_FFFF, 32'd3,         5'd2,  32'h5555_5555},
    '{3'b111, 32'd100,       32'd7,         5'd3,  32'd2},
    '{3'b100, 32'd5,         32'd0,         5'd4,  32'hFFFF_FFFF},
    '{3'b110, 32'd5,         32'd0,         5'd5,  32'd5},
    '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h8000_0000},
    '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'd0},
    '{3'b101, 32'h8000_0000, 32'd1,         5'd8,  32'h8000_0000},
    '{3'b100, 32'd7,         32'hFFFF_FFFE, 5'd9,  32'hFFFF_FFFD},
    '{3'b110, 32'd7,         32'hFFFF_FFFE, 5'd10, 32'd1},
    '{3'b000, 32'hFFFF_FFFF, 32'd3,         5'd11, 32'h5555_5555},
    '{3'b010, 32'd100,       32'd7,         5'd13, 32'd14},
    '{3'b111, 32'h1234_5678, 32'd0,         5'd14, 32'h1234_5678},
    '{3'b100, 32'h8000_0000, 32'd2,         5'd15, 32'hC000_0000}
  };

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_result", result, 32'd0);
    chk("reset_rd", 32'(rd_out), 32'd0);

    // Consecutive vectors are issued in the IDLE cycle right after DONE.
    foreach (vecs[i]) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd);
      wait_valid(vecs[i].exp, vecs[i].rd);
    end

    // Starts arriving mid-calculation must not disturb the accepted op.
    issue(3'b101, 32'd81, 32'd9, 5'd3);
    repeat (3) begin
      repeat (4) @(posedge clk);
      #1 start = 1'b1; funct3 = 3'b100; rs1_data = 32'd5; rs2_data = 32'd0; rd_in = 5'd7;
      @(posedge clk);
      #1 start = 1'b0;
    end
    wait_valid(32'd9, 5'd3);

    // Flush in the tenth CALC cycle kills the op without a valid pulse.
    issue(3'b100, 32'd100, 32'd3, 5'd9);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    issue(3'b111, 32'd100, 32'd3, 5'd10);
    wait_valid(32'd1, 5'd10);

    // Reset mid-calculation returns every output to zero.
    issue(3'b101, 32'hFFFF_FFFF, 32'd3, 5'd21);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    issue(3'b110, 32'hFFFF_FF9C, 32'd7, 5'd22);
    wait_valid(32'hFFFF_FFFE, 5'd22);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
